// File: rtl/fritz_fault_harness.sv
`default_nettype none
// ============================================================================
// Module      : fritz_fault_harness
// Description : Multi-lane C9 redundant-network evaluator with one
//               programmable stuck-at fault and a detection counter.
// Revision    : 1.0 - initial release
// ============================================================================
module fritz_fault_harness #(
    parameter int LANES  = 4,
    parameter int LANE_W = 2,
    parameter int CNT_W  = 16
) (
    input  logic                 CK,
    input  logic                 RST,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [4*LANES-1:0]   in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [LANES-1:0]     out_data,
    input  logic                 flt_we,
    input  logic [LANE_W-1:0]    flt_lane,
    input  logic [3:0]           flt_node,
    input  logic                 flt_val,
    input  logic                 det_clr,
    output logic [CNT_W-1:0]     det_cnt,
    output logic [LANES-1:0]     det_lanes
);

    localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};

    logic [LANE_W-1:0] r_flt_lane;
    logic [3:0]        r_flt_node;
    logic              r_flt_val;

    logic              r_out_valid;
    logic [LANES-1:0]  r_out_data;
    logic [CNT_W-1:0]  r_det_cnt;
    logic [LANES-1:0]  r_det_lanes;

    logic [LANES-1:0]  w_y;
    logic              w_accept;
    logic              w_dev;

    // Lanes at or beyond LANES never match, so an out-of-range lane disables the fault.
    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic [3:0] w_g;
        logic       w_hit;
        logic [8:1] w_frc;
        logic       w1, w2, w3, w4, w5, w6, w7, w8;

        assign w_g   = in_data[4*i +: 4];
        assign w_hit = (r_flt_lane == LANE_W'(i));

        for (genvar k = 1; k <= 8; k++) begin : g_node
            assign w_frc[k] = w_hit && (r_flt_node == 4'(k));
        end

        assign w1 = w_frc[1] ? r_flt_val : ~w_g[1];
        assign w2 = w_frc[2] ? r_flt_val : (w_g[2] | w_g[3]);
        assign w3 = w_frc[3] ? r_flt_val : ~(w_g[0] & w1);
        assign w4 = w_frc[4] ? r_flt_val : (w1 & w_g[2]);
        assign w5 = w_frc[5] ? r_flt_val : (w2 | w_g[3]);
        assign w6 = w_frc[6] ? r_flt_val : (w3 & w4 & w2);
        assign w7 = w_frc[7] ? r_flt_val : (w_g[2] & w5);
        assign w8 = w_frc[8] ? r_flt_val : ~w_g[2];

        assign w_y[i] = w6 | w7 | w8;
    end

    assign in_ready = ~r_out_valid | out_ready;
    assign w_accept = in_valid & in_ready;
    assign w_dev    = ~&w_y;

    // A write lands at the clock edge, so a beat accepted alongside it sees the old config.
    always_ff @(posedge CK or posedge RST) begin
        if (RST) begin
            r_flt_lane <= '0;
            r_flt_node <= '0;
            r_flt_val  <= 1'b0;
        end else if (flt_we) begin
            r_flt_lane <= flt_lane;
            r_flt_node <= flt_node;
            r_flt_val  <= flt_val;
        end
    end

    always_ff @(posedge CK or posedge RST) begin
        if (RST) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '1;
        end else if (w_accept) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_y;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    always_ff @(posedge CK or posedge RST) begin
        if (RST) begin
            r_det_cnt   <= '0;
            r_det_lanes <= '0;
        end else if (det_clr) begin
            r_det_cnt   <= '0;
            r_det_lanes <= '0;
        end else if (w_accept) begin
            if (w_dev && (r_det_cnt != c_cnt_max)) begin
                r_det_cnt <= r_det_cnt + 1'b1;
            end
            r_det_lanes <= r_det_lanes | ~w_y;
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign det_cnt   = r_det_cnt;
    assign det_lanes = r_det_lanes;

endmodule
`default_nettype wire
